// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter
package mem_arb_pkg;
   localparam int ADDR_W_DEF = 30;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;
   typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;
   typedef enum logic {REQ_IF, REQ_D} req_id_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous memory port between fetch and load/store
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy,
   output logic [CNT_W-1:0]  if_gnt_cnt,
   output logic [CNT_W-1:0]  d_gnt_cnt
);
   state_t  state;
   logic    rr_ptr;
   logic    gnt_any;
   req_id_t winner;
   // grants are gated by rst_n so an asserted reset silences them immediately
   always_comb begin
      gnt_any     = rst_n && state == IDLE && (if_req || d_req);
      winner      = (if_req && (!d_req || rr_ptr)) ? REQ_IF : REQ_D;
      if_gnt      = gnt_any && winner == REQ_IF;
      d_gnt       = gnt_any && winner == REQ_D;
      mem_addr    = if_gnt ? if_addr : d_gnt ? d_addr : '0;
      mem_wr_en   = d_gnt && d_we;
      mem_data_in = d_gnt ? d_wdata : '0;
      if_rvalid   = state == RESP_IF;
      d_rvalid    = state == RESP_D;
      if_rdata    = if_rvalid ? mem_data_out : '0;
      d_rdata     = d_rvalid ? mem_data_out : '0;
      busy        = state != IDLE || gnt_any;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= 1'b0;
      end else begin
         if (gnt_any && if_req && d_req) rr_ptr <= ~rr_ptr;
         state <= if_gnt ? RESP_IF : (d_gnt && !d_we) ? RESP_D : IDLE;
      end
   sat_counter #(.WIDTH(CNT_W)) u_if_cnt (.clk(clk), .rst_n(rst_n), .inc(if_gnt), .count(if_gnt_cnt));
   sat_counter #(.WIDTH(CNT_W)) u_d_cnt  (.clk(clk), .rst_n(rst_n), .inc(d_gnt),  .count(d_gnt_cnt));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the arbiter against a behavioural synchronous memory
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [29:0] if_addr = '0, d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wr_en, busy;
   logic [31:0] if_rdata, d_rdata, mem_data_in, mem_data_out;
   logic [29:0] mem_addr;
   logic [15:0] if_gnt_cnt, d_gnt_cnt;
   logic        s_if_req = 1'b0;
   logic [31:0] s_mem_rd = 32'h0;
   logic        s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_mem_wr_en, s_busy;
   logic [31:0] s_if_rdata, s_d_rdata, s_mem_data_in;
   logic [29:0] s_mem_addr;
   logic [1:0]  s_if_gnt_cnt, s_d_gnt_cnt;
   logic [31:0] mem [16];
   logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
   int          n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .busy(busy), .if_gnt_cnt(if_gnt_cnt), .d_gnt_cnt(d_gnt_cnt)
   );
   mem_arbiter #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .if_req(s_if_req), .if_addr(30'd0), .if_gnt(s_if_gnt), .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(30'd0), .d_wdata(32'd0),
      .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
      .mem_addr(s_mem_addr), .mem_wr_en(s_mem_wr_en), .mem_data_in(s_mem_data_in), .mem_data_out(s_mem_rd),
      .busy(s_busy), .if_gnt_cnt(s_if_gnt_cnt), .d_gnt_cnt(s_d_gnt_cnt)
   );
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr[3:0]] <= mem_data_in;
      mem_data_out <= mem[mem_addr[3:0]];
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[1] = 32'h20020005;
      mem[3] = 32'h3C3C0003;
      if_req = 1'b1;
      #2;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_if_cnt", if_gnt_cnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      tick(); rst_n = 1'b1; if_addr = 30'd1;
      #1;
      chk("f_if_gnt", if_gnt, 1);
      chk("f_d_gnt", d_gnt, 0);
      chk("f_mem_addr", mem_addr, 1);
      chk("f_wr_en", mem_wr_en, 0);
      chk("f_busy", busy, 1);
      tick(); #1;
      chk("f_no_gnt_resp", if_gnt, 0);
      chk("f_rvalid", if_rvalid, 1);
      chk("f_rdata", if_rdata, 32'h20020005);
      chk("f_cnt", if_gnt_cnt, 1);
      chk("f_busy_resp", busy, 1);
      if_req = 1'b0;
      tick(); #1;
      chk("f_rvalid_off", if_rvalid, 0);
      chk("f_rdata_off", if_rdata, 0);
      chk("f_idle_busy", busy, 0);
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1; if_req = 1'b1; d_req = 1'b1; d_addr = 30'd3; if_addr = 30'd1;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("rr_d_gnt", d_gnt, (g % 2 == 0));
         chk("rr_if_gnt", if_gnt, (g % 2 == 1));
         chk("rr_addr", mem_addr, (g % 2 == 0) ? 3 : 1);
         tick(); #1;
         chk("rr_d_rvalid", d_rvalid, (g % 2 == 0));
         chk("rr_if_rvalid", if_rvalid, (g % 2 == 1));
         chk("rr_rdata", (g % 2 == 0) ? d_rdata : if_rdata, (g % 2 == 0) ? 32'h3C3C0003 : 32'h20020005);
         tick();
      end
      chk("rr_if_cnt", if_gnt_cnt, 2);
      chk("rr_d_cnt", d_gnt_cnt, 2);
      if_req = 1'b0; d_we = 1'b1; d_addr = 30'd2; d_wdata = 32'hDEADBEEF;
      for (int w = 0; w < 3; w++) begin
         #1;
         chk("wr_gnt", d_gnt, 1);
         chk("wr_en", mem_wr_en, 1);
         chk("wr_data", mem_data_in, 32'hDEADBEEF);
         chk("wr_addr", mem_addr, 2);
         chk("wr_no_rvalid", d_rvalid, 0);
         tick();
      end
      d_we = 1'b0;
      #1;
      chk("rb_gnt", d_gnt, 1);
      chk("rb_wr_en", mem_wr_en, 0);
      tick(); d_req = 1'b0; #1;
      chk("rb_rvalid", d_rvalid, 1);
      chk("rb_rdata", d_rdata, 32'hDEADBEEF);
      chk("rb_d_cnt", d_gnt_cnt, 6);
      tick(); #1;
      chk("rb_rvalid_off", d_rvalid, 0);
      chk("rb_rdata_off", d_rdata, 0);
      d_req = 1'b1; d_addr = 30'd3;
      #1;
      chk("rd_gnt", d_gnt, 1);
      tick(); d_req = 1'b0; rst_n = 1'b0; #1;
      chk("rr_rst_rvalid", d_rvalid, 0);
      chk("rr_rst_rdata", d_rdata, 0);
      chk("rr_rst_busy", busy, 0);
      chk("rr_rst_d_cnt", d_gnt_cnt, 0);
      chk("rr_rst_if_cnt", if_gnt_cnt, 0);
      tick(); rst_n = 1'b1; #1;
      chk("post_rst_rvalid", d_rvalid, 0);
      chk("post_rst_busy", busy, 0);
      tick(); #1;
      chk("post_rst_rvalid2", d_rvalid, 0);
      s_if_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("sat_gnt", s_if_gnt, 1);
         tick(); #1;
         chk("sat_cnt", s_if_gnt_cnt, sat_exp[k]);
         chk("sat_resp_gnt", s_if_gnt, 0);
         tick();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter CNT_W, default 16, grant-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W, if_gnt out 1, if_rvalid out 1, if_rdata out DATA_W: instruction-fetch requester, read-only.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W: load/store requester.
REQ-008 SHALL have ports mem_addr out ADDR_W, mem_wr_en out 1, mem_data_in out DATA_W, mem_data_out in DATA_W: single synchronous memory port, read data valid one cycle after the address edge.
REQ-009 SHALL have ports busy out 1, if_gnt_cnt out CNT_W, d_gnt_cnt out CNT_W: status/debug.

Function
REQ-010 SHALL implement FSM states IDLE, RESP_IF, RESP_D.
REQ-011 In IDLE with any req high, SHALL grant exactly one requester that cycle: one-cycle gnt pulse, combinational from req.
REQ-012 Grant cycle SHALL drive mem_addr/mem_wr_en/mem_data_in from the winner's fields; mem_wr_en=1 only for a d_we=1 grant, else 0.
REQ-013 No grant: mem_wr_en=0, mem_addr=0, mem_data_in=0.
REQ-014 Requester SHALL hold req and fields until gnt; arbiter samples fields only in grant cycle.
REQ-015 Arbitration: only one req high -> it wins; both high -> round-robin via rr_ptr (0 = data first, 1 = fetch first).
REQ-016 rr_ptr SHALL toggle to favour the loser after every grant made while both reqs were high; unchanged otherwise.
REQ-017 Read grant (fetch, or data with d_we=0) SHALL move IDLE -> RESP_IF / RESP_D.
REQ-018 In RESP_x, x_rvalid=1 for exactly one cycle with x_rdata = mem_data_out; then -> IDLE; no grant issued in RESP_x.
REQ-019 Read latency: gnt in cycle N -> rvalid in cycle N+1; next grant earliest N+2.
REQ-020 Write grant SHALL stay in IDLE, no rvalid; back-to-back writes may be granted every cycle.
REQ-021 if_rdata/d_rdata SHALL be 0 when the corresponding rvalid is 0.
REQ-022 busy SHALL be 1 in RESP_IF/RESP_D or in any cycle a gnt is asserted.
REQ-023 if_gnt_cnt/d_gnt_cnt SHALL increment by 1 per grant and saturate at all-ones (no wrap).
REQ-024 req deasserted in RESP_x SHALL not affect the pending rvalid.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, rr_ptr 0, both counters 0, all gnt/rvalid/rdata 0, mem_wr_en 0.
REQ-026 Reset during RESP_x SHALL drop the pending read; no rvalid after release.
REQ-027 First rising edge after rst_n deassertion SHALL allow a grant.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the FSM state enum, requester-id enum (REQ_IF, REQ_D) and default width constants.
REQ-029 Counters SHALL use one sub-module, sat_counter (parameter WIDTH; inc, count), instantiated twice.
REQ-030 Size target: 120-400 lines RTL including sub-module.

Verification
REQ-031 Reset, then if_req=1, if_addr=1, mem[1]=32'h20020005 -> if_gnt at N, if_rvalid at N+1 with if_rdata=32'h20020005, if_gnt_cnt=1.
REQ-032 if_req and d_req (read, addr 3) both held high for 8 cycles after reset -> grants alternate D,IF,D,IF; each read returns one cycle after grant.
REQ-033 d_req=1, d_we=1, d_addr=2, d_wdata=32'hDEADBEEF, 3 cycles -> 3 consecutive d_gnt, mem_wr_en high 3 cycles, no d_rvalid; subsequent read addr 2 returns 32'hDEADBEEF.
REQ-034 rst_n pulsed low in RESP_D -> d_rvalid never asserted, counters 0, busy 0.
REQ-035 CNT_W=2, 5 fetch grants -> if_gnt_cnt sequence 1,2,3,3,3.
